scr1_dmem_lane_align: RTL and testbench

//  Sits between scr1_pipe_lsu and the DMEM router/TCM port, one outstanding access.

---
 rtl/scr1_dmem_lane_align_pkg.sv | 46 ++++
 rtl/scr1_dmem_lane_map.sv | 38 +++
 rtl/scr1_dmem_lane_align.sv | 143 ++++++++++++++
 tb/tb_scr1_dmem_lane_align.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_dmem_lane_align_pkg.sv
`default_nettype none
// =============================================================================
// Module : scr1_dmem_lane_align_pkg
// Brief  : Shared memory-interface types and widths for the DMEM lane aligner.
// Rev    : 1.0  initial release
// =============================================================================
package scr1_dmem_lane_align_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;
  localparam int SCR1_DMEM_BE_W   = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_ALIGN_IDLE = 2'b00,
    SCR1_DMEM_ALIGN_BUSY = 2'b01,
    SCR1_DMEM_ALIGN_ERR  = 2'b10
  } type_scr1_dmem_align_fsm_e;

  function automatic logic scr1_dmem_misalign(input type_scr1_mem_width_e width,
                                              input logic [1:0] offset);
    case (width)
      SCR1_MEM_WIDTH_HWORD: return offset[0];
      SCR1_MEM_WIDTH_WORD:  return |offset;
      default:              return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/scr1_dmem_lane_map.sv
`default_nettype none
// =============================================================================
// Module : scr1_dmem_lane_map
// Brief  : Width/offset to byte-enable and lane-replicated write data mapping.
// Rev    : 1.0  initial release
// =============================================================================
module scr1_dmem_lane_map
  import scr1_dmem_lane_align_pkg::*;
(
  input  type_scr1_mem_width_e          i_width,
  input  logic [1:0]                    i_offset,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   i_wdata,
  output logic [SCR1_DMEM_BE_W-1:0]     o_be,
  output logic [SCR1_DMEM_DWIDTH-1:0]   o_wdata
);

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    case (i_width)
      SCR1_MEM_WIDTH_BYTE: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        o_be    = 4'b0011 << {i_offset[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      SCR1_MEM_WIDTH_WORD: begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/scr1_dmem_lane_align.sv
`default_nettype none
// =============================================================================
// Module : scr1_dmem_lane_align
// Brief  : LSU-to-DMEM lane aligner, one outstanding access, misalign rejection.
//          Optional response timeout: SCR1_DMEM_RESP_TIMEOUT_EN.
// Rev    : 1.0  initial release
// =============================================================================
module scr1_dmem_lane_align
  import scr1_dmem_lane_align_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lsu2dmem_req_i,
  input  type_scr1_mem_cmd_e            lsu2dmem_cmd_i,
  input  type_scr1_mem_width_e          lsu2dmem_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   lsu2dmem_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   lsu2dmem_wdata_i,
  output logic                          dmem2lsu_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem2lsu_rdata_o,
  output type_scr1_mem_resp_e           dmem2lsu_resp_o,
  output logic                          dmem_req_o,
  output type_scr1_mem_cmd_e            dmem_cmd_o,
  output logic [SCR1_DMEM_BE_W-1:0]     dmem_be_o,
  output logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata_o,
  input  logic                          dmem_req_ack_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata_i,
  input  type_scr1_mem_resp_e           dmem_resp_i
);

  type_scr1_dmem_align_fsm_e r_state;
  type_scr1_dmem_align_fsm_e w_state_next;
  logic [1:0]                r_offset;
  type_scr1_mem_width_e      r_width;
  type_scr1_mem_cmd_e        r_cmd;
  type_scr1_mem_resp_e       w_resp;
  logic                      w_misalign;
  logic                      w_capture;
  logic                      w_timeout;
  logic                      w_txn_unused;

  assign w_misalign = scr1_dmem_misalign(lsu2dmem_width_i, lsu2dmem_addr_i[1:0]);
  assign w_capture  = (r_state == SCR1_DMEM_ALIGN_IDLE) & ~rst & lsu2dmem_req_i
                    & ~w_misalign & dmem_req_ack_i;

`ifdef SCR1_DMEM_RESP_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [c_CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != SCR1_DMEM_ALIGN_BUSY)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
    end
  end

  // Counter is 0 in the first BUSY cycle, so the forced error lands on BUSY cycle TIMEOUT_CYC.
  assign w_timeout = (r_state == SCR1_DMEM_ALIGN_BUSY)
                   & (r_tmo_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_cfg_unused;
  assign w_cfg_unused = (TIMEOUT_CYC != 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SCR1_DMEM_ALIGN_IDLE;
      r_offset <= 2'b00;
      r_width  <= SCR1_MEM_WIDTH_BYTE;
      r_cmd    <= SCR1_MEM_CMD_RD;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_offset <= lsu2dmem_addr_i[1:0];
        r_width  <= lsu2dmem_width_i;
        r_cmd    <= lsu2dmem_cmd_i;
      end
    end
  end

  // Width and command of the in-flight access are held for debug observation only.
  assign w_txn_unused = ^{r_width, r_cmd};

  always_comb begin
    w_state_next       = r_state;
    w_resp             = SCR1_MEM_RESP_IDLE;
    dmem_req_o         = 1'b0;
    dmem2lsu_req_ack_o = 1'b0;
    if (!rst) begin
      case (r_state)
        SCR1_DMEM_ALIGN_IDLE: begin
          if (lsu2dmem_req_i) begin
            if (w_misalign) begin
              dmem2lsu_req_ack_o = 1'b1;
              w_state_next       = SCR1_DMEM_ALIGN_ERR;
            end else begin
              dmem_req_o         = 1'b1;
              dmem2lsu_req_ack_o = dmem_req_ack_i;
              if (dmem_req_ack_i) begin
                w_state_next = SCR1_DMEM_ALIGN_BUSY;
              end
            end
          end
        end
        SCR1_DMEM_ALIGN_BUSY: begin
          w_resp = dmem_resp_i;
          if (dmem_resp_i != SCR1_MEM_RESP_IDLE) begin
            w_state_next = SCR1_DMEM_ALIGN_IDLE;
          end else if (w_timeout) begin
            w_resp       = SCR1_MEM_RESP_RDY_ER;
            w_state_next = SCR1_DMEM_ALIGN_IDLE;
          end
        end
        SCR1_DMEM_ALIGN_ERR: begin
          w_resp       = SCR1_MEM_RESP_RDY_ER;
          w_state_next = SCR1_DMEM_ALIGN_IDLE;
        end
        default: w_state_next = SCR1_DMEM_ALIGN_IDLE;
      endcase
    end
  end

  assign dmem2lsu_resp_o  = w_resp;
  assign dmem2lsu_rdata_o = (w_resp == SCR1_MEM_RESP_RDY_OK)
                          ? (dmem_rdata_i >> {r_offset, 3'b000}) : '0;

  assign dmem_cmd_o  = lsu2dmem_cmd_i;
  assign dmem_addr_o = {lsu2dmem_addr_i[SCR1_DMEM_AWIDTH-1:2], 2'b00};

  scr1_dmem_lane_map u_lane_map (
    .i_width  (lsu2dmem_width_i),
    .i_offset (lsu2dmem_addr_i[1:0]),
    .i_wdata  (lsu2dmem_wdata_i),
    .o_be     (dmem_be_o),
    .o_wdata  (dmem_wdata_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_scr1_dmem_lane_align.sv
`default_nettype none
// =============================================================================
// Module : tb_scr1_dmem_lane_align
// Brief  : Self-checking bench for scr1_dmem_lane_align (directed + random).
// Rev    : 1.0  initial release
// =============================================================================
module tb_scr1_dmem_lane_align;
  import scr1_dmem_lane_align_pkg::*;

`ifdef SCR1_DMEM_RESP_TIMEOUT_EN
  localparam int TCYC = 4;
`else
  localparam int TCYC = 255;
`endif

  logic                 clk;
  logic                 rst;
  logic                 req;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic                 lsu_ack;
  logic [31:0]          lsu_rdata;
  type_scr1_mem_resp_e  lsu_resp;
  logic                 mem_req;
  type_scr1_mem_cmd_e   mem_cmd;
  logic [3:0]           mem_be;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_ack;
  logic [31:0]          mem_rdata;
  type_scr1_mem_resp_e  mem_resp;

  int n_checks = 0;
  int n_errors = 0;

  scr1_dmem_lane_align #(.TIMEOUT_CYC(TCYC)) dut (
    .clk                (clk),
    .rst                (rst),
    .lsu2dmem_req_i     (req),
    .lsu2dmem_cmd_i     (cmd),
    .lsu2dmem_width_i   (width),
    .lsu2dmem_addr_i    (addr),
    .lsu2dmem_wdata_i   (wdata),
    .dmem2lsu_req_ack_o (lsu_ack),
    .dmem2lsu_rdata_o   (lsu_rdata),
    .dmem2lsu_resp_o    (lsu_resp),
    .dmem_req_o         (mem_req),
    .dmem_cmd_o         (mem_cmd),
    .dmem_be_o          (mem_be),
    .dmem_addr_o        (mem_addr),
    .dmem_wdata_o       (mem_wdata),
    .dmem_req_ack_i     (mem_ack),
    .dmem_rdata_i       (mem_rdata),
    .dmem_resp_i        (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: access size in bytes n = 2**width.
  function automatic bit m_mis(input int w, input logic [31:0] a);
    return (int'(a[1:0]) % (1 << w)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input int w, input logic [31:0] a);
    int n    = 1 << w;
    int base = (int'(a[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] m_wdata(input int w, input logic [31:0] d);
    int n = 1 << w;
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] d, input logic [31:0] a);
    return d >> (8 * int'(a[1:0]));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input int w, input logic [31:0] a, input logic [31:0] d);
    req   = 1'b1;
    cmd   = type_scr1_mem_cmd_e'(1'(c));
    width = type_scr1_mem_width_e'(2'(w));
    addr  = a;
    wdata = d;
  endtask

  task automatic access(input int c, input int w, input logic [31:0] a, input logic [31:0] d,
                        input int ack_dly, input int resp_dly, input logic [31:0] rd,
                        input bit err);
    drive(c, w, a, d);
    if (m_mis(w, a)) begin
      mem_ack = 1'b0;
      @(negedge clk);
      check("mis_dmem_req", 32'(mem_req), 0);
      check("mis_ack", 32'(lsu_ack), 1);
      tick();
      req = 1'b0;
      @(negedge clk);
      check("mis_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_RDY_ER));
      check("mis_rdata", lsu_rdata, 0);
      tick();
      @(negedge clk);
      check("mis_back_idle", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
      tick();
      return;
    end
    for (int i = 0; i <= ack_dly; i++) begin
      mem_ack = (i == ack_dly);
      @(negedge clk);
      check("req_dmem_req", 32'(mem_req), 1);
      check("req_ack", 32'(lsu_ack), 32'(mem_ack));
      check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
      check("req_be", 32'(mem_be), 32'(m_be(w, a)));
      check("req_wdata", mem_wdata, m_wdata(w, d));
      check("req_cmd", 32'(mem_cmd), 32'(c));
      check("req_resp_idle", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
      tick();
    end
    req     = 1'b0;
    mem_ack = 1'b0;
    for (int j = 0; j < resp_dly; j++) begin
      @(negedge clk);
      check("busy_dmem_req", 32'(mem_req), 0);
      check("busy_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
      tick();
    end
    mem_resp  = err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    mem_rdata = rd;
    @(negedge clk);
    check("resp", 32'(lsu_resp), 32'(mem_resp));
    check("rdata", lsu_rdata, err ? 32'h0 : m_rdata(rd, a));
    tick();
    mem_resp  = SCR1_MEM_RESP_IDLE;
    mem_rdata = $urandom;
  endtask

  initial begin
    rst       = 1'b1;
    drive(0, 2, 32'h0000_0010, 32'h1111_2222);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    mem_resp  = SCR1_MEM_RESP_RDY_OK;
    tick();
    tick();
    @(negedge clk);
    check("rst_dmem_req", 32'(mem_req), 0);
    check("rst_ack", 32'(lsu_ack), 0);
    check("rst_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
    check("rst_rdata", lsu_rdata, 0);
    tick();
    rst      = 1'b0;
    req      = 1'b0;
    mem_ack  = 1'b0;
    mem_resp = SCR1_MEM_RESP_IDLE;
    tick();

    // SB to 0x103
    drive(1, 0, 32'h0000_0103, 32'h0000_00AB);
    mem_ack = 1'b1;
    @(negedge clk);
    check("sb_addr", mem_addr, 32'h0000_0100);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_ack", 32'(lsu_ack), 1);
    tick();
    req     = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("sb_busy_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
    tick();
    mem_resp = SCR1_MEM_RESP_RDY_OK;
    @(negedge clk);
    check("sb_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    tick();
    mem_resp = SCR1_MEM_RESP_IDLE;

    // LHU from 0x202
    drive(0, 1, 32'h0000_0202, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    check("lhu_be", 32'(mem_be), 32'hC);
    tick();
    req       = 1'b0;
    mem_ack   = 1'b0;
    mem_resp  = SCR1_MEM_RESP_RDY_OK;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("lhu_rdata", lsu_rdata, 32'h0000_1234);
    tick();
    mem_resp = SCR1_MEM_RESP_IDLE;

    // misaligned LW
    access(0, 2, 32'h0000_0301, 32'h0, 0, 0, 32'h0, 1'b0);

    // LW with delayed ack, then a stray response in IDLE
    access(0, 2, 32'h0000_0400, 32'h0, 3, 1, 32'hCAFE_F00D, 1'b0);
    mem_resp  = SCR1_MEM_RESP_RDY_OK;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stray_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
    check("stray_rdata", lsu_rdata, 0);
    tick();
    mem_resp = SCR1_MEM_RESP_IDLE;

    // reset pulse while BUSY
    drive(1, 2, 32'h0000_0500, 32'h5555_AAAA);
    mem_ack = 1'b1;
    tick();
    req     = 1'b0;
    mem_ack = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("rstbusy_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
    tick();
    rst      = 1'b0;
    mem_resp = SCR1_MEM_RESP_RDY_OK;
    @(negedge clk);
    check("rstbusy_late_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
    check("rstbusy_late_rdata", lsu_rdata, 0);
    tick();
    mem_resp = SCR1_MEM_RESP_IDLE;
    access(1, 2, 32'h0000_0504, 32'h0BAD_CAFE, 0, 0, 32'h0, 1'b0);

`ifdef SCR1_DMEM_RESP_TIMEOUT_EN
    drive(0, 2, 32'h0000_0600, 32'h0);
    mem_ack = 1'b1;
    tick();
    req     = 1'b0;
    mem_ack = 1'b0;
    for (int k = 1; k <= TCYC; k++) begin
      @(negedge clk);
      check("tmo_resp", 32'(lsu_resp),
            (k == TCYC) ? 32'(SCR1_MEM_RESP_RDY_ER) : 32'(SCR1_MEM_RESP_IDLE));
      tick();
    end
    mem_resp = SCR1_MEM_RESP_RDY_OK;
    @(negedge clk);
    check("tmo_late_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
    tick();
    mem_resp = SCR1_MEM_RESP_IDLE;
`else
    drive(0, 2, 32'h0000_0600, 32'h0);
    mem_ack = 1'b1;
    tick();
    drive(1, 2, 32'h0000_0700, 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("wait_dmem_req", 32'(mem_req), 0);
      check("wait_ack", 32'(lsu_ack), 0);
      check("wait_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_IDLE));
      tick();
    end
    req       = 1'b0;
    mem_ack   = 1'b0;
    mem_resp  = SCR1_MEM_RESP_RDY_OK;
    mem_rdata = 32'h7654_3210;
    @(negedge clk);
    check("wait_final_resp", 32'(lsu_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("wait_final_rdata", lsu_rdata, 32'h7654_3210);
    tick();
    mem_resp = SCR1_MEM_RESP_IDLE;
`endif

    for (int t = 0; t < 60; t++) begin
      access(int'($urandom_range(1, 0)), int'($urandom_range(2, 0)), $urandom, $urandom,
             int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), $urandom,
             ($urandom_range(3, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
